// File: rtl/decode_pkg.sv
// Shared widths, condition codes, decoded-entry type and condition evaluation
// for the decode stage.
package decode_pkg;

  localparam int REG_ADDR_W_DEF = 3;
  localparam int OPCODE_W_DEF   = 4;
  localparam int COND_W_DEF     = 2;
  localparam int INST_W_DEF     = 16;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    COND_AL = 2'd0,
    COND_EQ = 2'd1,
    COND_NE = 2'd2,
    COND_MI = 2'd3
  } cond_e;

  typedef struct packed {
    logic [COND_W_DEF-1:0]     cond;
    logic [OPCODE_W_DEF-1:0]   op_code;
    logic [REG_ADDR_W_DEF-1:0] dest;
    logic [REG_ADDR_W_DEF-1:0] src1;
    logic [REG_ADDR_W_DEF-1:0] src2;
    logic                      shift;
    logic                      exec;
  } decoded_inst_t;

  // Cond arrives zero-extended so one function serves any COND_W; codes above MI never run.
  function automatic logic eval_cond(input logic [31:0] cond, input logic flag_z,
                                     input logic flag_n);
    logic result;
    case (cond)
      32'(COND_AL): result = 1'b1;
      32'(COND_EQ): result = flag_z;
      32'(COND_NE): result = !flag_z;
      32'(COND_MI): result = flag_n;
      default:      result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/inst_field_split.sv
// Combinational slicer: instruction word plus flags into a packed entry laid out
// like decoded_inst_t (cond, op_code, dest, src1, src2, shift, exec).
module inst_field_split
  import decode_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int OPCODE_W   = OPCODE_W_DEF,
  parameter int COND_W     = COND_W_DEF,
  parameter int INST_W     = INST_W_DEF
) (
  input  logic [INST_W-1:0]                            inst,
  input  logic                                         flag_z,
  input  logic                                         flag_n,
  output logic [COND_W+OPCODE_W+3*REG_ADDR_W+1:0]      fields
);

  localparam int SRC2_LSB = 1;
  localparam int SRC1_LSB = SRC2_LSB + REG_ADDR_W;
  localparam int DEST_LSB = SRC1_LSB + REG_ADDR_W;
  localparam int OP_LSB   = DEST_LSB + REG_ADDR_W;

  logic [COND_W-1:0] cond;

  assign cond   = inst[INST_W-1 -: COND_W];
  assign fields = {cond,
                   inst[OP_LSB   +: OPCODE_W],
                   inst[DEST_LSB +: REG_ADDR_W],
                   inst[SRC1_LSB +: REG_ADDR_W],
                   inst[SRC2_LSB +: REG_ADDR_W],
                   inst[0],
                   eval_cond(32'(cond), flag_z, flag_n)};

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a one-entry output register plus one skid entry.
// Optional statistics counters are enabled with the DECODE_STATS_EN macro.
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int OPCODE_W   = OPCODE_W_DEF,
  parameter int COND_W     = COND_W_DEF,
  parameter int INST_W     = INST_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     in_inst,
  input  logic                  flag_z,
  input  logic                  flag_n,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COND_W-1:0]     out_cond,
  output logic [OPCODE_W-1:0]   out_op_code,
  output logic [REG_ADDR_W-1:0] out_dest_reg,
  output logic [REG_ADDR_W-1:0] out_src_reg_1,
  output logic [REG_ADDR_W-1:0] out_src_reg_2,
  output logic                  out_shift,
  output logic                  out_exec
`ifdef DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0]      stat_decoded,
  output logic [CNT_W-1:0]      stat_squashed
`endif
);

  if (INST_W != COND_W + OPCODE_W + 3 * REG_ADDR_W + 1) begin : g_bad_inst_w
    $error("decode_stage: INST_W must equal COND_W+OPCODE_W+3*REG_ADDR_W+1");
  end
  if (COND_W < 2) begin : g_bad_cond_w
    $error("decode_stage: COND_W must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("decode_stage: CNT_W must be at least 1");
  end

  typedef struct packed {
    logic [COND_W-1:0]     cond;
    logic [OPCODE_W-1:0]   op_code;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  shift;
    logic                  exec;
  } entry_t;

  logic [$bits(entry_t)-1:0] split_bits;
  entry_t new_entry;
  entry_t out_entry;
  entry_t skid_entry;
  logic   skid_valid;
  logic   accept;
  logic   drain;

  inst_field_split #(
    .REG_ADDR_W(REG_ADDR_W),
    .OPCODE_W  (OPCODE_W),
    .COND_W    (COND_W),
    .INST_W    (INST_W)
  ) u_split (
    .inst  (in_inst),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .fields(split_bits)
  );

  assign new_entry = entry_t'(split_bits);
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = out_valid && out_ready;

  // A full skid implies in_ready=0, so draining it never races a new acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_entry  <= '0;
      skid_entry <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_entry  <= skid_entry;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) out_entry <= new_entry;
      end
    end else if (accept) begin
      skid_entry <= new_entry;
      skid_valid <= 1'b1;
    end
  end

  assign out_cond      = out_entry.cond;
  assign out_op_code   = out_entry.op_code;
  assign out_dest_reg  = out_entry.dest;
  assign out_src_reg_1 = out_entry.src1;
  assign out_src_reg_2 = out_entry.src2;
  assign out_shift     = out_entry.shift;
  assign out_exec      = out_entry.exec;

`ifdef DECODE_STATS_EN
  // Counts what downstream actually saw, so flush does not suppress or clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded  <= '0;
      stat_squashed <= '0;
    end else if (drain) begin
      if (stat_decoded != '1) stat_decoded <= stat_decoded + CNT_W'(1);
      if (!out_entry.exec && stat_squashed != '1) stat_squashed <= stat_squashed + CNT_W'(1);
    end
  end
`else
  logic unused_drain;
  assign unused_drain = drain;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a two-deep FIFO reference
// model; also covers the stats counters when DECODE_STATS_EN is defined.
module tb_decode_stage;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_inst;
  logic        flag_z;
  logic        flag_n;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_cond;
  logic [3:0]  out_op_code;
  logic [2:0]  out_dest_reg;
  logic [2:0]  out_src_reg_1;
  logic [2:0]  out_src_reg_2;
  logic        out_shift;
  logic        out_exec;
`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] stat_decoded;
  logic [CNT_W-1:0] stat_squashed;
`endif

  typedef struct {
    logic [1:0] cond;
    logic [3:0] op;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
    logic       shift;
    logic       exec;
  } ref_t;

  ref_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_decoded = 0;
  int   exp_squashed = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cond     (out_cond),
    .out_op_code  (out_op_code),
    .out_dest_reg (out_dest_reg),
    .out_src_reg_1(out_src_reg_1),
    .out_src_reg_2(out_src_reg_2),
    .out_shift    (out_shift),
    .out_exec     (out_exec)
`ifdef DECODE_STATS_EN
    ,
    .stat_decoded (stat_decoded),
    .stat_squashed(stat_squashed)
`endif
  );

  // Field extraction straight from the documented bit layout.
  function automatic ref_t decodeRef(input logic [15:0] inst, input logic z, input logic n);
    ref_t r;
    int   word;
    word    = int'(inst);
    r.cond  = 2'((word / 16384) % 4);
    r.op    = 4'((word / 1024) % 16);
    r.dest  = 3'((word / 128) % 8);
    r.src1  = 3'((word / 16) % 8);
    r.src2  = 3'((word / 2) % 8);
    r.shift = 1'(word % 2);
    case (r.cond)
      2'd0:    r.exec = 1'b1;
      2'd1:    r.exec = z;
      2'd2:    r.exec = !z;
      default: r.exec = n;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      checkOutput({tag, ".cond"}, 32'(out_cond), 32'(q[0].cond));
      checkOutput({tag, ".op_code"}, 32'(out_op_code), 32'(q[0].op));
      checkOutput({tag, ".dest"}, 32'(out_dest_reg), 32'(q[0].dest));
      checkOutput({tag, ".src1"}, 32'(out_src_reg_1), 32'(q[0].src1));
      checkOutput({tag, ".src2"}, 32'(out_src_reg_2), 32'(q[0].src2));
      checkOutput({tag, ".shift"}, 32'(out_shift), 32'(q[0].shift));
      checkOutput({tag, ".exec"}, 32'(out_exec), 32'(q[0].exec));
    end
`ifdef DECODE_STATS_EN
    checkOutput({tag, ".stat_decoded"}, 32'(stat_decoded), 32'(exp_decoded));
    checkOutput({tag, ".stat_squashed"}, 32'(stat_squashed), 32'(exp_squashed));
`endif
  endtask

  // Called at a falling edge: drives one cycle, advances the model, checks after the edge.
  task automatic applyStimulus(input string tag, input logic inv, input logic [15:0] inst,
                               input logic z, input logic n, input logic ordy,
                               input logic fl);
    logic acc;
    logic hs;
    in_valid  = inv;
    in_inst   = inst;
    flag_z    = z;
    flag_n    = n;
    out_ready = ordy;
    flush     = fl;
    acc = inv && (q.size() < 2) && !fl;
    hs  = (q.size() > 0) && ordy;
    if (hs) begin
      if (exp_decoded < (2 ** CNT_W) - 1) exp_decoded++;
      if (!q[0].exec && exp_squashed < (2 ** CNT_W) - 1) exp_squashed++;
    end
    if (fl) q.delete();
    else begin
      if (hs) void'(q.pop_front());
      if (acc) q.push_back(decodeRef(inst, z, n));
    end
    @(posedge clk);
    @(negedge clk);
    checkState(tag);
  endtask

  task automatic asyncReset();
    @(posedge clk);
    #2;
    checkOutput("areset.pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("areset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("areset.in_ready", 32'(in_ready), 32'd1);
    q.delete();
    exp_decoded  = 0;
    exp_squashed = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1;
    checkState("areset.release");
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    flag_z    = 1'b0;
    flag_n    = 1'b0;
    out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    checkState("reset");
    checkOutput("reset.cond", 32'(out_cond), 32'd0);
    checkOutput("reset.op_code", 32'(out_op_code), 32'd0);
    checkOutput("reset.exec", 32'(out_exec), 32'd0);
    @(negedge clk);

    $display("[TB] basic decode and squash");
    applyStimulus("basic", 1'b1, 16'h4EA3, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("basic.k_valid", 32'(out_valid), 32'd1);
    checkOutput("basic.k_cond", 32'(out_cond), 32'd1);
    checkOutput("basic.k_op", 32'(out_op_code), 32'd3);
    checkOutput("basic.k_dest", 32'(out_dest_reg), 32'd5);
    checkOutput("basic.k_src1", 32'(out_src_reg_1), 32'd2);
    checkOutput("basic.k_src2", 32'(out_src_reg_2), 32'd1);
    checkOutput("basic.k_shift", 32'(out_shift), 32'd1);
    checkOutput("basic.k_exec", 32'(out_exec), 32'd1);
    applyStimulus("basic.drain", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("squash", 1'b1, 16'h4EA3, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("squash.k_exec", 32'(out_exec), 32'd0);
    checkOutput("squash.k_op", 32'(out_op_code), 32'd3);
    checkOutput("squash.k_dest", 32'(out_dest_reg), 32'd5);
    applyStimulus("squash.drain", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef DECODE_STATS_EN
    checkOutput("squash.k_stat_squashed", 32'(stat_squashed), 32'd1);
    checkOutput("squash.k_stat_decoded", 32'(stat_decoded), 32'd2);
`endif

    $display("[TB] backpressure");
    applyStimulus("bp.1", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("bp.2", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp.k_ready_low", 32'(in_ready), 32'd0);
    applyStimulus("bp.3", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp.k_ready_still_low", 32'(in_ready), 32'd0);
    checkOutput("bp.k_hold_shift", 32'(out_shift), 32'd1);
    applyStimulus("bp.4", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp.k_second_src2", 32'(out_src_reg_2), 32'd1);
    checkOutput("bp.k_second_shift", 32'(out_shift), 32'd0);
    applyStimulus("bp.5", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp.k_third_shift", 32'(out_shift), 32'd1);
    applyStimulus("bp.6", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp.k_empty", 32'(out_valid), 32'd0);

    $display("[TB] flush with both entries full");
    applyStimulus("fl.1", 1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("fl.2", 1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fl.k_full", 32'(in_ready), 32'd0);
    applyStimulus("fl.3", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("fl.k_valid", 32'(out_valid), 32'd0);
    checkOutput("fl.k_ready", 32'(in_ready), 32'd1);
    applyStimulus("fl.4", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("fl.k_not_accepted", 32'(out_valid), 32'd0);

    $display("[TB] full throughput");
    for (int i = 0; i < 8; i++) begin
      applyStimulus("tput", 1'b1, 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      checkOutput("tput.k_ready", 32'(in_ready), 32'd1);
      checkOutput("tput.k_valid", 32'(out_valid), 32'd1);
    end

    $display("[TB] async reset mid-stream");
    applyStimulus("ar.fill", 1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
    asyncReset();
`ifdef DECODE_STATS_EN
    checkOutput("areset.k_stat_decoded", 32'(stat_decoded), 32'd0);
`endif
    @(negedge clk);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
